// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//   Direct-mapped branch target buffer. Each entry holds a valid bit, a tag,
//   a 32-bit target and a CTR_BITS saturating direction counter. Lookup is
//   combinational. Updates from Execute are written on the rising clock edge.
//   A lookup in the same cycle as an update sees the contents from before
//   that update.
//
//   Optional feature: define BP_GSHARE_EN to enable gshare indexing. The
//   lookup and update index then become the PC index XOR a global history
//   register. Without the macro the plain PC index is used and no history
//   register exists.
//
// Parameters
//   ENTRIES   number of table entries (power of two, 4..256)
//   TAG_BITS  tag width stored per entry
//   CTR_BITS  saturating counter width (1..4)
//
// Ports
//   CLK               clock, all state updates on the rising edge
//   RST               asynchronous active-high reset
//   PC_F              fetch PC used for lookup
//   Predict_Taken_F   fetch PC predicted taken
//   Predict_Target_F  predicted next PC (stored target or PC_F+4)
//   Update_En_E       a branch/jump resolves in Execute
//   Jump_En_E         the resolving instruction is an unconditional jump
//   PC_E              PC of the resolving instruction
//   Branch_Taken_E    resolved direction
//   PC_Target_E       resolved target
//   Mispredict_Count  saturating count of mispredicted updates
// ---------------------------------------------------------------------------
module branch_predictor #(
    parameter int ENTRIES  = 16,
    parameter int TAG_BITS = 8,
    parameter int CTR_BITS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] PC_F,
    output logic        Predict_Taken_F,
    output logic [31:0] Predict_Target_F,
    input  logic        Update_En_E,
    input  logic        Jump_En_E,
    input  logic [31:0] PC_E,
    input  logic        Branch_Taken_E,
    input  logic [31:0] PC_Target_E,
    output logic [15:0] Mispredict_Count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_BITS-1:0] CTR_ONES = '1;
    localparam logic [CTR_BITS-1:0] CTR_WNT  = CTR_ONES >> 1;   // 0 followed by ones
    localparam logic [CTR_BITS-1:0] CTR_WT   = ~CTR_WNT;        // 1 followed by zeros

    function automatic logic [IDX_W-1:0] pc_idx(input logic [31:0] pc);
        return pc[IDX_W+1:2];
    endfunction

    function automatic logic [TAG_BITS-1:0] pc_tag(input logic [31:0] pc);
        return pc[IDX_W+2 +: TAG_BITS];
    endfunction

    logic                valid_q  [ENTRIES];
    logic                valid_d  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [TAG_BITS-1:0] tag_d    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [31:0]         target_d [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
    logic [CTR_BITS-1:0] ctr_d    [ENTRIES];
    logic [15:0]         mis_cnt_q, mis_cnt_d;

    logic [IDX_W-1:0]    idx_f_s, idx_e_s;
    logic                hit_f_s, hit_e_s, pred_e_s;

    // Only the index/tag slices of the PCs are consumed.
    logic                unused_pc_s;
    assign unused_pc_s = ^{PC_F, PC_E};

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0]    hist_q, hist_d;
    assign idx_f_s = pc_idx(PC_F) ^ hist_q;
    assign idx_e_s = pc_idx(PC_E) ^ hist_q;
`else
    assign idx_f_s = pc_idx(PC_F);
    assign idx_e_s = pc_idx(PC_E);
`endif

    // Fetch-side lookup from current (pre-update) table contents.
    always_comb begin
        hit_f_s         = valid_q[idx_f_s] && (tag_q[idx_f_s] == pc_tag(PC_F));
        Predict_Taken_F = hit_f_s && ctr_q[idx_f_s][CTR_BITS-1];
        if (Predict_Taken_F) begin
            Predict_Target_F = target_q[idx_f_s];
        end else begin
            Predict_Target_F = PC_F + 32'd4;
        end
    end

    // Execute-side update: next-state for the table and mispredict counter.
    always_comb begin
        valid_d   = valid_q;
        tag_d     = tag_q;
        target_d  = target_q;
        ctr_d     = ctr_q;
        mis_cnt_d = mis_cnt_q;
`ifdef BP_GSHARE_EN
        hist_d    = hist_q;
`endif
        hit_e_s   = valid_q[idx_e_s] && (tag_q[idx_e_s] == pc_tag(PC_E));
        pred_e_s  = hit_e_s && ctr_q[idx_e_s][CTR_BITS-1];

        if (Update_En_E) begin
            if ((pred_e_s != Branch_Taken_E) && (mis_cnt_q != 16'hFFFF)) begin
                mis_cnt_d = mis_cnt_q + 16'd1;
            end else begin
                mis_cnt_d = mis_cnt_q;
            end

            if (hit_e_s) begin
                if (Jump_En_E) begin
                    ctr_d[idx_e_s]    = CTR_ONES;
                    target_d[idx_e_s] = PC_Target_E;
                end else if (Branch_Taken_E) begin
                    if (ctr_q[idx_e_s] != CTR_ONES) begin
                        ctr_d[idx_e_s] = ctr_q[idx_e_s] + 1'b1;
                    end else begin
                        ctr_d[idx_e_s] = ctr_q[idx_e_s];
                    end
                    target_d[idx_e_s] = PC_Target_E;
                end else begin
                    if (ctr_q[idx_e_s] != '0) begin
                        ctr_d[idx_e_s] = ctr_q[idx_e_s] - 1'b1;
                    end else begin
                        ctr_d[idx_e_s] = ctr_q[idx_e_s];
                    end
                end
            end else if (Branch_Taken_E) begin
                // Miss on a taken outcome: allocate, evicting any occupant.
                valid_d[idx_e_s]  = 1'b1;
                tag_d[idx_e_s]    = pc_tag(PC_E);
                target_d[idx_e_s] = PC_Target_E;
                ctr_d[idx_e_s]    = Jump_En_E ? CTR_ONES : CTR_WT;
            end else begin
                valid_d[idx_e_s]  = valid_q[idx_e_s];
            end

`ifdef BP_GSHARE_EN
            if (!Jump_En_E) begin
                hist_d = {hist_q[IDX_W-2:0], Branch_Taken_E};
            end else begin
                hist_d = hist_q;
            end
`endif
        end else begin
            mis_cnt_d = mis_cnt_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
                ctr_q[i]    <= CTR_WNT;
            end
            mis_cnt_q <= 16'd0;
`ifdef BP_GSHARE_EN
            hist_q    <= '0;
`endif
        end else begin
            valid_q   <= valid_d;
            tag_q     <= tag_d;
            target_q  <= target_d;
            ctr_q     <= ctr_d;
            mis_cnt_q <= mis_cnt_d;
`ifdef BP_GSHARE_EN
            hist_q    <= hist_d;
`endif
        end
    end

    assign Mispredict_Count = mis_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    logic        CLK;
    logic        RST;
    logic [31:0] PC_F;
    logic        Predict_Taken_F;
    logic [31:0] Predict_Target_F;
    logic        Update_En_E;
    logic        Jump_En_E;
    logic [31:0] PC_E;
    logic        Branch_Taken_E;
    logic [31:0] PC_Target_E;
    logic [15:0] Mispredict_Count;

    int total = 0;
    int bad   = 0;

    branch_predictor #(.ENTRIES(16), .TAG_BITS(8), .CTR_BITS(2)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .PC_F             (PC_F),
        .Predict_Taken_F  (Predict_Taken_F),
        .Predict_Target_F (Predict_Target_F),
        .Update_En_E      (Update_En_E),
        .Jump_En_E        (Jump_En_E),
        .PC_E             (PC_E),
        .Branch_Taken_E   (Branch_Taken_E),
        .PC_Target_E      (PC_Target_E),
        .Mispredict_Count (Mispredict_Count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Lookup at pc and compare prediction against hand-computed values.
    task automatic look(input string tag, input logic [31:0] pc,
                        input logic taken, input logic [31:0] tgt);
        PC_F = pc;
        #1;
        chk({tag, "_taken"}, {31'd0, Predict_Taken_F}, {31'd0, taken});
        chk({tag, "_target"}, Predict_Target_F, tgt);
    endtask

    // One update cycle; returns 1 time unit after the edge.
    task automatic upd(input logic [31:0] pc, input logic taken,
                       input logic jump, input logic [31:0] tgt);
        PC_E           = pc;
        Branch_Taken_E = taken;
        Jump_En_E      = jump;
        PC_Target_E    = tgt;
        Update_En_E    = 1'b1;
        @(posedge CLK);
        #1;
        Update_En_E    = 1'b0;
    endtask

    initial begin
        RST = 1'b1; PC_F = 32'h100; Update_En_E = 1'b0; Jump_En_E = 1'b0;
        PC_E = 32'h0; Branch_Taken_E = 1'b0; PC_Target_E = 32'h0;
        #12;
        look("reset_lookup", 32'h100, 1'b0, 32'h104);
        chk("reset_cnt", {16'd0, Mispredict_Count}, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;

        // First taken update allocates weakly taken; miss predicted not-taken.
        upd(32'h100, 1'b1, 1'b0, 32'h80);
        look("alloc", 32'h100, 1'b1, 32'h80);
        chk("alloc_cnt", {16'd0, Mispredict_Count}, 32'd1);

        // Saturate up at 3, then walk down to 0.
        upd(32'h100, 1'b1, 1'b0, 32'h80);
        upd(32'h100, 1'b1, 1'b0, 32'h80);
        upd(32'h100, 1'b1, 1'b0, 32'h80);
        look("sat_hi", 32'h100, 1'b1, 32'h80);
        chk("sat_hi_cnt", {16'd0, Mispredict_Count}, 32'd1);
        upd(32'h100, 1'b0, 1'b0, 32'h0);
        look("nt1", 32'h100, 1'b1, 32'h80);
        upd(32'h100, 1'b0, 1'b0, 32'h0);
        look("nt2", 32'h100, 1'b0, 32'h104);
        upd(32'h100, 1'b0, 1'b0, 32'h0);
        upd(32'h100, 1'b0, 1'b0, 32'h0);
        chk("nt4_cnt", {16'd0, Mispredict_Count}, 32'd3);
        // Counter sits at 0: one taken gives 1, still not-taken.
        upd(32'h100, 1'b1, 1'b0, 32'h88);
        look("sat_lo", 32'h100, 1'b0, 32'h104);
        chk("sat_lo_cnt", {16'd0, Mispredict_Count}, 32'd4);

        // Aliasing: 0x140 shares index 0, different tag.
        look("alias_miss", 32'h140, 1'b0, 32'h144);
        upd(32'h140, 1'b1, 1'b0, 32'h300);
        look("alias_hit", 32'h140, 1'b1, 32'h300);
        look("alias_evicted", 32'h100, 1'b0, 32'h104);
        chk("alias_cnt", {16'd0, Mispredict_Count}, 32'd5);

        // Not-taken miss must not allocate.
        upd(32'h180, 1'b0, 1'b0, 32'h700);
        look("nt_noalloc", 32'h140, 1'b1, 32'h300);
        look("nt_noalloc_miss", 32'h180, 1'b0, 32'h184);
        chk("nt_noalloc_cnt", {16'd0, Mispredict_Count}, 32'd5);

        // Jump allocates with all-ones: survives one not-taken decrement.
        upd(32'h1C0, 1'b1, 1'b1, 32'h400);
        upd(32'h1C0, 1'b0, 1'b0, 32'h0);
        look("jump_strong", 32'h1C0, 1'b1, 32'h400);
        chk("jump_cnt", {16'd0, Mispredict_Count}, 32'd7);

        // Same-cycle lookup and first update: old contents visible.
        PC_F = 32'h200; PC_E = 32'h200; Branch_Taken_E = 1'b1;
        Jump_En_E = 1'b0; PC_Target_E = 32'h500; Update_En_E = 1'b1;
        #1;
        chk("rbw_same", {31'd0, Predict_Taken_F}, 32'd0);
        @(posedge CLK); #1;
        Update_En_E = 1'b0;
        look("rbw_next", 32'h200, 1'b1, 32'h500);
        chk("rbw_cnt", {16'd0, Mispredict_Count}, 32'd8);

        // Forced mispredicts: jump hit resolved not-taken, every cycle.
        PC_E = 32'h200; Branch_Taken_E = 1'b0; Jump_En_E = 1'b1;
        PC_Target_E = 32'h600; Update_En_E = 1'b1;
        for (int i = 0; i < 65536; i++) @(posedge CLK);
        #1;
        chk("cnt_sat", {16'd0, Mispredict_Count}, 32'h0000FFFF);
        look("sat_pred", 32'h200, 1'b1, 32'h600);

        // Reset mid-run with update still asserted, no clock edge.
        RST = 1'b1;
        #1;
        chk("rst_cnt", {16'd0, Mispredict_Count}, 32'd0);
        look("rst_miss_200", 32'h200, 1'b0, 32'h204);
        look("rst_miss_1c0", 32'h1C0, 1'b0, 32'h1C4);
        Update_En_E = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;

        // First edge after reset release accepts an update.
        upd(32'h100, 1'b1, 1'b0, 32'h80);
        look("post_rst", 32'h100, 1'b1, 32'h80);
        chk("post_rst_cnt", {16'd0, Mispredict_Count}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
